// File: rtl/im_port_arbiter_pkg.sv
// Shared definitions for the instruction-memory port arbiter.
//   ST_BOOT / ST_RUN : arbiter state encodings
//   ADDR_W_DEF       : default byte-address width
//   DATA_W_DEF       : default word width
//   WORD_OFS_MASK    : byte-offset bits inside a 32-bit word
package im_port_arbiter_pkg;

  localparam int unsigned ADDR_W_DEF = 16;
  localparam int unsigned DATA_W_DEF = 32;

  localparam logic [0:0] ST_BOOT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  localparam logic [1:0] WORD_OFS_MASK = 2'b11;

endpackage

// File: rtl/im_starve_counter.sv
// Saturating wait counter for the loader port.
// Ports:
//   clk_i  : clock, rising edge
//   rst_i  : asynchronous reset, active-high
//   inc_i  : count one more waiting cycle (saturates at LIMIT)
//   clr_i  : return to zero (dominates inc_i)
//   sat_o  : counter has reached LIMIT
module im_starve_counter #(
  parameter int unsigned LIMIT = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic inc_i,
  input  logic clr_i,
  output logic sat_o
);

  localparam int unsigned CNT_W = $clog2(LIMIT + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign sat_o = (cnt_q == CNT_W'(LIMIT));

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && !sat_o) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/im_port_arbiter.sv
// Shares the single-port instruction memory between CPU fetch and the loader.
// BOOT: only the loader is served; fetch stalls until ld_done.
// RUN : fetch has priority; a waiting loader request is forced through once
//       it has waited STARVE_LIMIT cycles.
// Ports:
//   clk, rst                      : clock, asynchronous active-high reset
//   if_req/if_addr/if_gnt         : fetch request, byte address, grant
//   if_rvalid/if_rdata/if_err     : fetch response (one cycle after grant)
//   ld_req/ld_we/ld_addr/ld_wdata : loader request
//   ld_done                       : one-cycle pulse ending BOOT
//   ld_gnt, ld_rvalid/ld_rdata/ld_err : loader grant and response
//   im_addr/im_we/im_wdata/im_dout: memory port (combinational read)
//   boot_mode                     : 1 while in BOOT
module im_port_arbiter
  import im_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W       = ADDR_W_DEF,
  parameter int unsigned DATA_W       = DATA_W_DEF,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_err,
  input  logic              ld_req,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_wdata,
  input  logic              ld_done,
  output logic              ld_gnt,
  output logic              ld_rvalid,
  output logic [DATA_W-1:0] ld_rdata,
  output logic              ld_err,
  output logic [ADDR_W-1:0] im_addr,
  output logic              im_we,
  output logic [DATA_W-1:0] im_wdata,
  input  logic [DATA_W-1:0] im_dout,
  output logic              boot_mode
);

  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~{{(ADDR_W-2){1'b0}}, WORD_OFS_MASK};

  logic [0:0] state_q, state_d;
  logic       boot;
  logic       starve_sat;

  logic              if_rvalid_q, if_err_q, ld_rvalid_q, ld_err_q;
  logic [DATA_W-1:0] if_rdata_q, ld_rdata_q;

  assign boot      = (state_q == ST_BOOT);
  assign boot_mode = boot;

  // Grants: at most one per cycle; loader wins in RUN only when fetch is idle
  // or the loader has waited its full budget.
  always_comb begin
    if_gnt = 1'b0;
    ld_gnt = 1'b0;
    if (boot) begin
      ld_gnt = ld_req;
    end else begin
      ld_gnt = ld_req & (~if_req | starve_sat);
      if_gnt = if_req & ~ld_gnt;
    end
  end

  always_comb begin
    im_addr = '0;
    if (if_gnt) begin
      im_addr = if_addr & ALIGN_MASK;
    end else if (ld_gnt) begin
      im_addr = ld_addr & ALIGN_MASK;
    end
  end

  assign im_we    = ld_gnt & ld_we;
  assign im_wdata = ld_wdata;

  // Counter only runs in RUN; BOOT keeps it cleared.
  im_starve_counter #(
    .LIMIT (STARVE_LIMIT)
  ) u_starve (
    .clk_i (clk),
    .rst_i (rst),
    .inc_i (~boot & ld_req & ~ld_gnt),
    .clr_i (boot | ld_gnt | ~ld_req),
    .sat_o (starve_sat)
  );

  always_comb begin
    state_d = state_q;
    if (boot && ld_done) begin
      state_d = ST_RUN;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_BOOT;
      if_rvalid_q <= 1'b0;
      if_err_q    <= 1'b0;
      if_rdata_q  <= '0;
      ld_rvalid_q <= 1'b0;
      ld_err_q    <= 1'b0;
      ld_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      if_rvalid_q <= if_gnt;
      if_err_q    <= if_gnt & |(if_addr[1:0] & WORD_OFS_MASK);
      ld_rvalid_q <= ld_gnt;
      ld_err_q    <= ld_gnt & |(ld_addr[1:0] & WORD_OFS_MASK);
      if (if_gnt) begin
        if_rdata_q <= im_dout;
      end
      if (ld_gnt) begin
        ld_rdata_q <= ld_we ? '0 : im_dout;
      end
    end
  end

  assign if_rvalid = if_rvalid_q;
  assign if_err    = if_err_q;
  assign if_rdata  = if_rdata_q;
  assign ld_rvalid = ld_rvalid_q;
  assign ld_err    = ld_err_q;
  assign ld_rdata  = ld_rdata_q;

endmodule

// File: doc/im_port_arbiter.md
Name: im_port_arbiter

Overview:
- Shares the single-port instruction memory (im_32k: combinational read, word write) between two requesters: the CPU fetch port and the program loader/debug port.
- After reset it holds the CPU off in a BOOT phase until the loader signals completion. It then switches to RUN, where fetch has priority and loader accesses are guaranteed service by a starvation counter.
- Sits between the IF stage and im_32k.

Parameters:
ADDR_W, 16, byte address width of both requesters and the memory
DATA_W, 32, word width
STARVE_LIMIT, 4, RUN-state cycles a pending loader request may wait before it is forced a grant (must be >= 1)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active-high
if_req  in  1  fetch request; held with if_addr stable until if_gnt
if_addr  in  ADDR_W  fetch byte address
if_gnt  out  1  fetch granted this cycle (combinational)
if_rvalid  out  1  fetch read data valid (registered, one cycle after if_gnt)
if_rdata  out  DATA_W  fetch read data
if_err  out  1  misaligned fetch; qualifies if_rvalid
ld_req  in  1  loader request; held with ld_* stable until ld_gnt
ld_we  in  1  loader write (1) / read (0)
ld_addr  in  ADDR_W  loader byte address
ld_wdata  in  DATA_W  loader write data
ld_done  in  1  one-cycle pulse: load complete
ld_gnt  out  1  loader granted this cycle (combinational)
ld_rvalid  out  1  loader read/write completion (registered)
ld_rdata  out  DATA_W  loader read data (0 for writes)
ld_err  out  1  misaligned loader access; qualifies ld_rvalid
im_addr  out  ADDR_W  memory address, word-aligned
im_we  out  1  memory write enable
im_wdata  out  DATA_W  memory write data
im_dout  in  DATA_W  memory combinational read data
boot_mode  out  1  1 while in BOOT

Behaviour:
- State register: BOOT, RUN. Reset value is BOOT.
- Reset values: all rvalid/err/rdata outputs 0, starvation counter 0, boot_mode 1.
- Reset is asynchronous. Asserting it mid-transaction drops any pending rvalid; no response is issued for that transaction.
- BOOT arbitration:
  - ld_gnt = ld_req; if_gnt = 0.
  - Fetch stalls indefinitely.
- BOOT to RUN transition: on ld_done at a clock edge.
  - If ld_done coincides with a granted loader access, that access completes normally and the state becomes RUN on the same edge.
- RUN arbitration:
  - Default winner is fetch when if_req = 1. Loader is granted when if_req = 0, or when starve_cnt == STARVE_LIMIT.
  - Exactly one grant per cycle; never both.
- Starvation counter (RUN only):
  - Increments, saturating at STARVE_LIMIT, on each cycle with ld_req = 1 and ld_gnt = 0.
  - Clears on ld_gnt or when ld_req = 0.
  - Held at 0 in BOOT.
- ld_done in RUN is ignored. RUN is left only by reset.
- Memory drive:
  - im_addr = winner's addr with bits [1:0] forced to 0.
  - im_we = ld_gnt & ld_we.
  - im_wdata = ld_wdata.
  - With no grant: im_addr holds 0 and im_we = 0.
- Response, 1-cycle latency:
  - On the edge ending a granted cycle, the grantee's rvalid is set to 1 for exactly one cycle.
  - rdata captures im_dout for reads and 0 for writes.
  - err = (addr[1:0] != 0).
  - Non-grantee rvalid is 0.
- Misaligned access is still performed at the aligned word and still returns data; err is the only indication.
- Back-to-back grants to the same requester are permitted every cycle, giving full throughput.
- Loader writes in RUN are allowed (self-modifying code). Ordering is strict program order across requesters, with no bypass.

Decomposition:
- Shared package/header holds: ST_BOOT/ST_RUN encodings, default ADDR_W/DATA_W, and the word-alignment mask constant.
- One natural sub-module: im_starve_counter (saturating counter with inc/clr/sat output, width clog2(STARVE_LIMIT+1)).
- Arbitration, FSM and response registers remain in the top.

Test Plan:
1. Reset, then if_req=1 at addr 0x3000 for 5 cycles in BOOT -> if_gnt=0 throughout, boot_mode=1, im_we=0.
2. BOOT: loader writes 0x00010203 to 0x3000, pulses ld_done, then reads 0x3000 -> ld_rvalid one cycle after each grant, read returns 0x00010203, boot_mode falls after the ld_done edge.
3. RUN: 10 sequential fetches from 0x3000 step 4 with words incrementing by 0x04040404 -> if_gnt every cycle, if_rdata matches each word one cycle after its grant.
4. RUN: if_req held high, ld_req read at 0x3004 with STARVE_LIMIT=4 -> ld_gnt on the 5th cycle only, if_gnt=0 that cycle, counter back to 0.
5. RUN: fetch at 0x3006 -> im_addr=0x3004, if_rvalid=1 with if_err=1 and data of word 0x3004.
6. Assert rst in the cycle after a fetch grant -> if_rvalid stays 0, state BOOT, all outputs at reset values.
